// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single port of a synchronous data BRAM between two requesters:
//   requester 0 : core load/store path (priority requester)
//   requester 1 : debug/loader master (guaranteed service via starvation count)
//
// Grants and the BRAM drive are combinational from the requests and the
// registered state. Read responses come back one cycle after the grant and
// are steered to the requester that issued the read.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   r0_* / r1_*         per-requester request (req/addr/wmask/wdata), grant,
//                       read-valid and read-data; wmask == 4'b0000 is a read
//   mem_en/addr/we/wdata  BRAM port drive
//   mem_rdata           BRAM read data, valid the cycle after a read access
//   starve_cnt          current requester 1 wait count (debug)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 13,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    r0_req,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [3:0]              r0_wmask,
    input  logic [4*BYTE_WIDTH-1:0] r0_wdata,
    output logic                    r0_gnt,
    output logic                    r0_rvalid,
    output logic [4*BYTE_WIDTH-1:0] r0_rdata,

    input  logic                    r1_req,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [3:0]              r1_wmask,
    input  logic [4*BYTE_WIDTH-1:0] r1_wdata,
    output logic                    r1_gnt,
    output logic                    r1_rvalid,
    output logic [4*BYTE_WIDTH-1:0] r1_rdata,

    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_we,
    output logic [4*BYTE_WIDTH-1:0] mem_wdata,
    input  logic [4*BYTE_WIDTH-1:0] mem_rdata,

    output logic [3:0]              starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_t;

    owner_t     r_resp_owner;
    owner_t     w_resp_owner_next;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_cnt_next;
    logic       w_force1;
    logic       w_r0_gnt;
    logic       w_r1_gnt;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_owner <= OWN_NONE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_resp_owner <= w_resp_owner_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    // Arbitration, BRAM drive and next-state logic
    always_comb begin
        w_force1          = 1'b0;
        w_r0_gnt          = 1'b0;
        w_r1_gnt          = 1'b0;
        mem_en            = 1'b0;
        mem_addr          = '0;
        mem_we            = 4'b0000;
        mem_wdata         = '0;
        w_starve_cnt_next = 4'd0;
        w_resp_owner_next = OWN_NONE;

        // Requester 1 normally yields to requester 0, but once it has waited
        // long enough it takes the port even if requester 0 is asking.
        w_force1 = r1_req && (r_starve_cnt >= LIMIT);
        w_r1_gnt = r1_req && (w_force1 || !r0_req);
        w_r0_gnt = r0_req && !w_r1_gnt;

        mem_en = w_r0_gnt || w_r1_gnt;
        if (w_r1_gnt) begin
            mem_addr  = r1_addr;
            mem_we    = r1_wmask;
            mem_wdata = r1_wdata;
        end else if (w_r0_gnt) begin
            mem_addr  = r0_addr;
            mem_we    = r0_wmask;
            mem_wdata = r0_wdata;
        end

        // Count consecutive denied cycles; saturate so it never wraps to 0
        // while requester 1 is still waiting.
        if (w_r1_gnt) begin
            w_starve_cnt_next = 4'd0;
        end else if (r1_req) begin
            w_starve_cnt_next = (r_starve_cnt == 4'd15) ? 4'd15 : r_starve_cnt + 4'd1;
        end else begin
            w_starve_cnt_next = 4'd0;
        end

        // Only reads produce a response next cycle.
        if (w_r0_gnt && (r0_wmask == 4'b0000)) begin
            w_resp_owner_next = OWN_R0;
        end else if (w_r1_gnt && (r1_wmask == 4'b0000)) begin
            w_resp_owner_next = OWN_R1;
        end
    end

    assign r0_gnt     = w_r0_gnt;
    assign r1_gnt     = w_r1_gnt;
    assign starve_cnt = r_starve_cnt;

    // Response steering: the owner sees BRAM data, the other side sees zero.
    assign r0_rvalid = (r_resp_owner == OWN_R0);
    assign r1_rvalid = (r_resp_owner == OWN_R1);
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int BW = 8;
    localparam int AW = 13;
    localparam int DW = 4 * BW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r1_req;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [3:0]    r0_wmask, r1_wmask;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [3:0]    starve_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .BYTE_WIDTH  (BW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_req    (r0_req),
        .r0_addr   (r0_addr),
        .r0_wmask  (r0_wmask),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_addr   (r1_addr),
        .r1_wmask  (r1_wmask),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .starve_cnt(starve_cnt)
    );

    // Synchronous BRAM model with byte enables and registered read.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (poke_en) begin
            bram[poke_addr] <= poke_data;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[mem_addr][b*BW +: BW] <= mem_wdata[b*BW +: BW];
            end
            if (mem_we == 4'b0000) mem_rdata <= bram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    task automatic drive0(input logic req, input logic [AW-1:0] a, input logic [3:0] m, input logic [DW-1:0] d);
        r0_req = req; r0_addr = a; r0_wmask = m; r0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic [AW-1:0] a, input logic [3:0] m, input logic [DW-1:0] d);
        r1_req = req; r1_addr = a; r1_wmask = m; r1_wdata = d;
    endtask

    // Advance to the next cycle: inputs change just after the rising edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive0(1'b0, '0, 4'b0000, '0);
        drive1(1'b0, '0, 4'b0000, '0);
        mem_rdata = '0;
        #1;

        poke(13'h0010, 32'hDEADBEEF);
        poke(13'h0005, 32'h11223344);
        poke(13'h0001, 32'hA1A1A1A1);
        poke(13'h0002, 32'hB2B2B2B2);
        poke(13'h0003, 32'hC3C3C3C3);

        // Reset state
        @(negedge clk);
        chk("rst_starve", 32'(starve_cnt), 32'd0);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Single read by r0
        drive0(1'b1, 13'h0010, 4'b0000, '0);
        @(negedge clk);
        chk("rd_r0_gnt", 32'(r0_gnt), 32'd1);
        chk("rd_r1_gnt", 32'(r1_gnt), 32'd0);
        chk("rd_mem_en", 32'(mem_en), 32'd1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h10);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        drive0(1'b0, '0, 4'b0000, '0);
        @(negedge clk);
        chk("rd_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
        chk("rd_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("rd_r1_rdata", r1_rdata, 32'd0);
        chk("rd_idle_mem_en", 32'(mem_en), 32'd0);
        next_cycle();

        // Byte write then read by r1
        drive1(1'b1, 13'h0005, 4'b0100, 32'h00AB0000);
        @(negedge clk);
        chk("bw_r1_gnt", 32'(r1_gnt), 32'd1);
        chk("bw_mem_we", 32'(mem_we), 32'h4);
        chk("bw_mem_wdata", mem_wdata, 32'h00AB0000);
        next_cycle();
        drive1(1'b1, 13'h0005, 4'b0000, '0);
        @(negedge clk);
        chk("bw_rd_gnt", 32'(r1_gnt), 32'd1);
        chk("bw_no_rvalid_after_wr", 32'(r1_rvalid), 32'd0);
        next_cycle();
        drive1(1'b0, '0, 4'b0000, '0);
        @(negedge clk);
        chk("bw_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("bw_r1_rdata", r1_rdata, 32'h11AB3344);
        chk("bw_r0_rvalid", 32'(r0_rvalid), 32'd0);
        next_cycle();

        // Contention: 4 r0 grants then a forced r1 grant, repeating
        drive0(1'b1, 13'h0010, 4'b0000, '0);
        drive1(1'b1, 13'h0005, 4'b0000, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("ct_starve_%0d", i), 32'(starve_cnt), 32'(i % 5));
            chk($sformatf("ct_r1_gnt_%0d", i), 32'(r1_gnt), 32'((i % 5) == 4));
            chk($sformatf("ct_r0_gnt_%0d", i), 32'(r0_gnt), 32'((i % 5) != 4));
            if (i > 0) begin
                chk($sformatf("ct_r1_rvalid_%0d", i), 32'(r1_rvalid), 32'(((i - 1) % 5) == 4));
                chk($sformatf("ct_r0_rvalid_%0d", i), 32'(r0_rvalid), 32'(((i - 1) % 5) != 4));
            end
            next_cycle();
        end
        drive0(1'b0, '0, 4'b0000, '0);
        drive1(1'b0, '0, 4'b0000, '0);
        @(negedge clk);
        chk("ct_end_starve", 32'(starve_cnt), 32'd0);
        chk("ct_end_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("ct_end_r1_rdata", r1_rdata, 32'h11AB3344);
        next_cycle();

        // Back-to-back alternation r0, r1, r0
        drive0(1'b1, 13'h0001, 4'b0000, '0);
        @(negedge clk);
        chk("bb0_r0_gnt", 32'(r0_gnt), 32'd1);
        chk("bb0_mem_en", 32'(mem_en), 32'd1);
        next_cycle();
        drive0(1'b0, '0, 4'b0000, '0);
        drive1(1'b1, 13'h0002, 4'b0000, '0);
        @(negedge clk);
        chk("bb1_r1_gnt", 32'(r1_gnt), 32'd1);
        chk("bb1_mem_en", 32'(mem_en), 32'd1);
        chk("bb1_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("bb1_r0_rdata", r0_rdata, 32'hA1A1A1A1);
        next_cycle();
        drive1(1'b0, '0, 4'b0000, '0);
        drive0(1'b1, 13'h0003, 4'b0000, '0);
        @(negedge clk);
        chk("bb2_r0_gnt", 32'(r0_gnt), 32'd1);
        chk("bb2_mem_en", 32'(mem_en), 32'd1);
        chk("bb2_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("bb2_r1_rdata", r1_rdata, 32'hB2B2B2B2);
        chk("bb2_r0_rvalid", 32'(r0_rvalid), 32'd0);
        next_cycle();
        drive0(1'b0, '0, 4'b0000, '0);
        @(negedge clk);
        chk("bb3_mem_en", 32'(mem_en), 32'd0);
        chk("bb3_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("bb3_r0_rdata", r0_rdata, 32'hC3C3C3C3);
        chk("bb3_r1_rvalid", 32'(r1_rvalid), 32'd0);
        next_cycle();

        // Reset between a read grant and its response
        drive0(1'b1, 13'h0010, 4'b0000, '0);
        drive1(1'b1, 13'h0002, 4'b0000, '0);
        @(negedge clk);
        chk("rr_r0_gnt", 32'(r0_gnt), 32'd1);
        next_cycle();
        drive0(1'b0, '0, 4'b0000, '0);
        drive1(1'b0, '0, 4'b0000, '0);
        chk("rr_starve_before", 32'(starve_cnt), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_async_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rr_async_starve", 32'(starve_cnt), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rr_post_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rr_post_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("rr_post_starve", 32'(starve_cnt), 32'd0);
        next_cycle();
        drive0(1'b1, 13'h0010, 4'b0000, '0);
        @(negedge clk);
        chk("rr_again_gnt", 32'(r0_gnt), 32'd1);
        next_cycle();
        drive0(1'b0, '0, 4'b0000, '0);
        @(negedge clk);
        chk("rr_again_rvalid", 32'(r0_rvalid), 32'd1);
        chk("rr_again_rdata", r0_rdata, 32'hDEADBEEF);
        next_cycle();

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_mem_en_%0d", i), 32'(mem_en), 32'd0);
            chk($sformatf("idle_mem_we_%0d", i), 32'(mem_we), 32'd0);
            chk($sformatf("idle_starve_%0d", i), 32'(starve_cnt), 32'd0);
            chk($sformatf("idle_rvalid_%0d", i), 32'({r0_rvalid, r1_rvalid}), 32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single port of the synchronous data BRAM between two requesters: requester 0 (core load/store path, after byte-lane alignment) and requester 1 (debug/loader master).
- Requester 0 has priority. A starvation counter guarantees requester 1 a grant after a bounded wait.
- The block routes each read response back to its owner and drives the BRAM word address, byte write-enables and write data.

Parameters:
- BYTE_WIDTH, 8, bits per byte lane; data width is 4*BYTE_WIDTH.
- ADDR_WIDTH, 13, BRAM word-address width.
- STARVE_LIMIT, 4, consecutive denied cycles of requester 1 before it is force-granted (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 access request
- r0_addr  in  ADDR_WIDTH  requester 0 word address
- r0_wmask  in  4  requester 0 byte write-enables; 4'b0000 = read
- r0_wdata  in  4*BYTE_WIDTH  requester 0 write data
- r0_gnt  out  1  requester 0 access accepted this cycle
- r0_rvalid  out  1  requester 0 read data valid
- r0_rdata  out  4*BYTE_WIDTH  requester 0 read data
- r1_req, r1_addr, r1_wmask, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  (same directions, widths and meanings, for requester 1)
- mem_en  out  1  BRAM enable
- mem_addr  out  ADDR_WIDTH  BRAM word address
- mem_we  out  4  BRAM byte write-enables
- mem_wdata  out  4*BYTE_WIDTH  BRAM write data
- mem_rdata  in  4*BYTE_WIDTH  BRAM read data, valid one cycle after mem_en with mem_we=0
- starve_cnt  out  4  current requester 1 wait count (debug visibility)

Behaviour:
- Reset (rst_n low, asynchronous): starve_cnt=0, resp_owner=NONE, r0_rvalid=r1_rvalid=0.
  - Grants and mem_* outputs are combinational from req and state, so with no requests they are 0.
- Request rules:
  - A requester holds req, addr, wmask and wdata stable until it sees gnt.
  - A requester may deassert req only after gnt.
  - A gnt in cycle N consumes exactly one access.
- Arbitration (combinational, same cycle):
  - force1 = r1_req && (starve_cnt >= STARVE_LIMIT).
  - r1_gnt = r1_req && (force1 || !r0_req).
  - r0_gnt = r0_req && !r1_gnt.
  - At most one grant per cycle.
- Memory drive:
  - mem_en = r0_gnt|r1_gnt.
  - mem_addr, mem_wdata and mem_we are muxed from the granted requester.
  - mem_we is 0 when nothing is granted.
- Starvation counter, evaluated each clk edge:
  - r1_gnt: set to 0.
  - r1_req && !r1_gnt: increment, saturating at 15.
  - !r1_req: set to 0.
- Response pipeline:
  - resp_owner is registered.
  - A granted read (wmask==0) sets it to that requester for the next cycle; otherwise it is set to NONE.
  - In cycle N+1: rK_rvalid = (resp_owner==K), and rK_rdata = mem_rdata.
  - The non-owner's rdata is driven to 0.
  - Writes never produce rvalid.
- Latency: read data arrives exactly 1 cycle after gnt. Back-to-back grants are allowed every cycle, giving full throughput.
- Write then read to the same address in consecutive cycles returns the new data, which relies on BRAM read-after-write ordering. Byte lanes with a 0 write-enable are untouched.
- Reset mid-operation: a pending response is dropped (no rvalid after reset release), and starve_cnt restarts at 0.
- Simultaneous r0_req and r1_req with starve_cnt < STARVE_LIMIT: r0 wins, and the r1 counter increments.

Test Plan:
- Single read: r0 reads addr 0x0010, which holds 0xDEADBEEF -> r0_gnt in cycle N; r0_rvalid=1 with r0_rdata=0xDEADBEEF in N+1; r1_rvalid stays 0.
- Byte write then read: r1 writes addr 0x0005 with wmask=4'b0100, wdata=0x00AB0000 over old 0x11223344, then reads the same address -> read returns 0x11AB3344, and rvalid does not follow the write.
- Contention and starvation: r0_req and r1_req held continuously with STARVE_LIMIT=4 -> r0 granted for 4 cycles (starve_cnt 1..4), r1 granted on the 5th cycle, starve_cnt returns to 0, and the pattern repeats 4:1.
- Back-to-back alternation: r0 reads 0x0001, then r1 reads 0x0002, then r0 reads 0x0003 in consecutive cycles -> rvalid alternates r0, r1, r0 one cycle delayed, each with the correct word; mem_en is high for 3 cycles.
- Reset mid-read: assert rst_n=0 asynchronously between a read grant and its response cycle -> no rvalid after release; starve_cnt=0; the first post-reset request is served normally.
- Idle: no requests for 10 cycles -> mem_en=0, mem_we=0, starve_cnt=0, and both rvalid outputs stay 0.
